// File: rtl/cpu_pkg.sv
// cpu_pkg: shared front-end types and constants for the CPU pipeline.
package cpu_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } t_fetch_entry;

    typedef enum logic {
        FETCH_RUN,
        FETCH_DRAIN
    } t_fetch_state;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: register-based instruction buffer with wrap-around pointers.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  t_fetch_entry               din,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output t_fetch_entry               head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    t_fetch_entry mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-based imem request issue, response buffering and redirect flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    t_fetch_state  state, state_next;
    logic [31:0]   pc, rsp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count, outstanding_dec, drop_next;
    logic          req_fire, drop, push, pop;
    t_fetch_entry  head;

    assign target          = {redirect_pc[31:2], 2'b00};
    assign outstanding_dec = outstanding - CW'(imem_rsp_valid);
    assign drop            = imem_rsp_valid && drop_cnt != '0;
    assign push            = imem_rsp_valid && !drop && !redirect_valid;
    assign pop             = inst_valid && inst_ready;
    // Credits count both in-flight words and buffered words, so a response always has a slot.
    assign imem_req_valid  = rst_n && state == FETCH_RUN && !redirect_valid &&
                             ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_addr   = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign inst_valid      = fifo_count != '0;
    assign instruction     = head.instr;
    assign inst_pc         = head.pc;

    always_comb begin
        drop_next  = redirect_valid ? outstanding_dec : drop_cnt - CW'(drop);
        state_next = redirect_valid ? (outstanding_dec != '0 ? FETCH_DRAIN : FETCH_RUN)
                                    : (drop_next == '0 ? FETCH_RUN : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_next;
            outstanding <= outstanding_dec + CW'(req_fire);
            if (redirect_valid) begin
                pc     <= target;
                rsp_pc <= target;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (push) rsp_pc <= rsp_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{instr: imem_rsp_data, pc: rsp_pc}),
        .count (fifo_count),
        .head  (head)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with an in-order memory model and an expected-word scoreboard.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h100;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } t_pend;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        imem_req_valid, imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        inst_valid, inst_ready = 0;
    logic [31:0] instruction, inst_pc;

    int checks = 0, errors = 0;
    int cyc = 0, lat = 1, n_acc = 0, n_pop = 0;
    logic [31:0] req_exp = RPC;
    t_pend        pend[$];
    t_fetch_entry sb[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a * 32'd3 + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the memory response, model handshakes, then settle just after the edge.
    task automatic step();
        t_fetch_entry e;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = mem_f(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        if (redirect_valid) begin
            chk("req_valid_in_redirect", 32'(imem_req_valid), 0);
            sb.delete();
            req_exp = {redirect_pc[31:2], 2'b00};
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, req_exp);
                pend.push_back('{addr: req_exp, due: cyc + lat});
                sb.push_back('{instr: mem_f(req_exp), pc: req_exp});
                req_exp += 4;
                n_acc++;
            end
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_inst observed_pc=%h expected=none", inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("instruction", instruction, e.instr);
                end
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 0;
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst_n = 0;
        redirect_valid = 0;
        imem_rsp_valid = 0;
        imem_req_ready = 1;
        inst_ready = rdy;
        lat = l;
        pend.delete();
        sb.delete();
        req_exp = RPC;
        n_acc = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        #1;
        cyc = 0;
    endtask

    task automatic run_pops(input int k, input int limit);
        int tgt = n_pop + k;
        int i = 0;
        while (n_pop < tgt && i < limit) begin
            step();
            i++;
        end
        chk("pop_timeout", 32'(n_pop >= tgt), 1);
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1;
        redirect_pc = t;
        step();
    endtask

    initial begin
        // Reset state and streaming at 1-cycle latency
        rst_n = 0;
        imem_req_ready = 1;
        inst_ready = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_inst_pc", inst_pc, 0);
        do_reset(1, 1);
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_req_addr", imem_req_addr, RPC);
        step();
        chk("no_bypass", 32'(inst_valid), 0);
        step();
        chk("min_latency_valid", 32'(inst_valid), 1);
        chk("min_latency_pc", inst_pc, RPC);
        run_pops(8, 40);

        // Decoder stalled: exactly FIFO_DEPTH requests, then resume
        do_reset(1, 0);
        repeat (8) step();
        chk("stall_accepts", 32'(n_acc), 2);
        chk("stall_req_valid", 32'(imem_req_valid), 0);
        chk("stall_inst_valid", 32'(inst_valid), 1);
        chk("stall_head_pc", inst_pc, RPC);
        inst_ready = 1;
        run_pops(6, 40);

        // Redirect with two late responses in flight
        do_reset(3, 1);
        step();
        step();
        chk("credit_full_req_valid", 32'(imem_req_valid), 0);
        redirect(32'h2000);
        chk("drain_req_valid_a", 32'(imem_req_valid), 0);
        chk("drain_inst_valid", 32'(inst_valid), 0);
        step();
        chk("drain_req_valid_b", 32'(imem_req_valid), 0);
        step();
        chk("after_drain_req_valid", 32'(imem_req_valid), 1);
        chk("after_drain_req_addr", imem_req_addr, 32'h2000);
        run_pops(3, 40);

        // Redirect coinciding with the only outstanding response; misaligned target
        do_reset(2, 1);
        step();
        imem_req_ready = 0;
        step();
        chk("one_outstanding_addr", imem_req_addr, RPC + 32'd4);
        redirect(32'h502);
        chk("same_cycle_run_valid", 32'(imem_req_valid), 1);
        chk("aligned_target", imem_req_addr, 32'h500);
        chk("stale_dropped_a", 32'(inst_valid), 0);
        step();
        chk("stale_dropped_b", 32'(inst_valid), 0);
        imem_req_ready = 1;
        run_pops(3, 40);

        // Second redirect while draining
        do_reset(3, 1);
        step();
        step();
        redirect(32'h3002);
        chk("drain1_req_valid", 32'(imem_req_valid), 0);
        redirect(32'h4000);
        chk("drain2_req_valid", 32'(imem_req_valid), 0);
        step();
        chk("redir2_req_valid", 32'(imem_req_valid), 1);
        chk("redir2_req_addr", imem_req_addr, 32'h4000);
        run_pops(3, 40);

        // Asynchronous reset with a full buffer, then restart and PC wrap
        do_reset(1, 0);
        repeat (6) step();
        chk("full_inst_valid", 32'(inst_valid), 1);
        rst_n = 0;
        #1;
        chk("async_inst_valid", 32'(inst_valid), 0);
        chk("async_req_valid", 32'(imem_req_valid), 0);
        do_reset(1, 1);
        chk("restart_req_addr", imem_req_addr, RPC);
        run_pops(4, 40);
        redirect(32'hFFFF_FFF8);
        run_pops(4, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
